// File: rtl/addsub_pkg.sv
// addsub_pkg: shared mode encodings, FSM state type and the round-robin pick helper for addsub_rr_scheduler.
package addsub_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  localparam int MAX_REQ = 32;
  typedef enum logic {ST_EMPTY, ST_FULL} state_t;
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid, input int unsigned ptr, input int unsigned n);
    logic [MAX_REQ-1:0] g;
    logic [4:0] idx;
    g = '0;
    for (int unsigned k = 0; k < n; k++) begin
      idx = 5'((ptr + k) % n);
      if (g == '0 && valid[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction
endpackage

// File: rtl/addsub_core.sv
// addsub_core: combinational WIDTH-bit add/sub with carry out; ovf output present when ADDSUB_OVF_EN is defined.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  logic             w_sub;
  logic [WIDTH-1:0] w_bx;
  assign w_sub = (mode == MODE_SUB);
  assign w_bx = b ^ {WIDTH{w_sub}};
  assign {carry, sum} = {1'b0, a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_sub};
`ifdef ADDSUB_OVF_EN
  // carry into the MSB recovered from the MSB sum bit
  assign ovf = (a[WIDTH-1] ^ w_bx[WIDTH-1] ^ sum[WIDTH-1]) ^ carry;
`endif
endmodule

// File: rtl/addsub_rr_scheduler.sv
// addsub_rr_scheduler: round-robin shares one add/sub core among N_REQ requesters, one-entry result register.
// Optional rsp_ovf output is enabled by defining ADDSUB_OVF_EN.
module addsub_rr_scheduler
  import addsub_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  input  logic [N_REQ-1:0]         req_mode,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic [$clog2(N_REQ)-1:0] rsp_id
`ifdef ADDSUB_OVF_EN
  ,
  output logic                     rsp_ovf
`endif
);
  localparam int IDW = $clog2(N_REQ);
  state_t           r_state, w_next;
  logic [IDW-1:0]   r_ptr, w_idx, w_ptr_nxt;
  logic [N_REQ-1:0] w_pick, w_grant;
  logic             w_can_accept, w_fire, w_mode, w_carry;
  logic [WIDTH-1:0] w_a, w_b, w_sum;
`ifdef ADDSUB_OVF_EN
  logic             w_ovf;
`endif
  assign w_can_accept = (r_state == ST_EMPTY) | rsp_ready;
  assign w_pick = N_REQ'(rr_pick(MAX_REQ'(req_valid), 32'(r_ptr), N_REQ));
  assign w_grant = w_can_accept ? w_pick : '0;
  assign w_fire = |w_grant;
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N_REQ; i++) if (w_grant[i]) w_idx = IDW'(i);
  end
  assign w_ptr_nxt = (w_idx == IDW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
  assign w_a = req_a[w_idx*WIDTH +: WIDTH];
  assign w_b = req_b[w_idx*WIDTH +: WIDTH];
  assign w_mode = req_mode[w_idx];
  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a(w_a),
    .b(w_b),
    .mode(w_mode),
    .sum(w_sum),
    .carry(w_carry)
`ifdef ADDSUB_OVF_EN
    ,
    .ovf(w_ovf)
`endif
  );
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else r_state <= w_next;
  end
  // a pop with a simultaneous grant keeps the register full (no bubble)
  always_comb begin
    w_next = (r_state == ST_EMPTY) ? (w_fire ? ST_FULL : ST_EMPTY)
                                   : ((rsp_ready && !w_fire) ? ST_EMPTY : ST_FULL);
  end
  always_comb begin
    req_ready = w_grant;
    rsp_valid = (r_state == ST_FULL);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_id    <= '0;
`ifdef ADDSUB_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else if (w_fire) begin
      r_ptr     <= w_ptr_nxt;
      rsp_sum   <= w_sum;
      rsp_carry <= w_carry;
      rsp_id    <= w_idx;
`ifdef ADDSUB_OVF_EN
      rsp_ovf   <= w_ovf;
`endif
    end
  end
endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// tb_addsub_rr_scheduler: directed and randomized checks of addsub_rr_scheduler against an arithmetic reference model.
module tb_addsub_rr_scheduler;
  localparam int N = 4;
  localparam int W = 4;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic [N-1:0]     req_mode = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [W-1:0]     rsp_sum;
  logic             rsp_carry;
  logic [1:0]       rsp_id;
`ifdef ADDSUB_OVF_EN
  logic             rsp_ovf;
`endif
  addsub_rr_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .req_mode(req_mode),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum),
    .rsp_carry(rsp_carry),
    .rsp_id(rsp_id)
`ifdef ADDSUB_OVF_EN
    ,
    .rsp_ovf(rsp_ovf)
`endif
  );
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_err = 0;
  bit m_full = 0;
  int m_ptr = 0, m_sum = 0, m_carry = 0, m_id = 0, m_ovf = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic set_req(input int i, input int a, input int b, input logic m);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    req_mode[i] = m;
  endtask
  function automatic int pick();
    if (m_full && !rsp_ready) return -1;
    for (int k = 0; k < N; k++) if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction
  // one clock: check grant before the edge, advance the model, check the response after it
  task automatic step();
    int g, a, b, r, sa, sb, sr;
    bit was_rst;
    #1;
    g = pick();
    was_rst = rst;
    chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    @(posedge clk);
    if (was_rst) begin
      m_full = 0; m_ptr = 0; m_sum = 0; m_carry = 0; m_id = 0; m_ovf = 0;
    end else if (g >= 0) begin
      a = int'(req_a[g*W +: W]);
      b = int'(req_b[g*W +: W]);
      sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
      sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
      r = req_mode[g] ? a - b : a + b;
      sr = req_mode[g] ? sa - sb : sa + sb;
      m_carry = req_mode[g] ? int'(a >= b) : int'(r >= (1 << W));
      m_sum = r & ((1 << W) - 1);
      m_ovf = int'(sr > (1 << (W - 1)) - 1 || sr < -(1 << (W - 1)));
      m_id = g;
      m_ptr = (g + 1) % N;
      m_full = 1;
    end else if (rsp_ready) m_full = 0;
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
    if (m_full || was_rst) begin
      chk("rsp_sum", 32'(rsp_sum), 32'(m_sum));
      chk("rsp_carry", 32'(rsp_carry), 32'(m_carry));
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
`ifdef ADDSUB_OVF_EN
      chk("rsp_ovf", 32'(rsp_ovf), 32'(m_ovf));
`endif
    end
  endtask
  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, 5, 3, addsub_pkg::MODE_ADD);
    req_valid = 4'b0001;
    step();
    chk("t1_add_sum", 32'(rsp_sum), 32'd8);
    chk("t1_add_carry", 32'(rsp_carry), 32'd0);
    chk("t1_add_id", 32'(rsp_id), 32'd0);
    set_req(0, 5, 3, addsub_pkg::MODE_SUB);
    step();
    chk("t1_sub_sum", 32'(rsp_sum), 32'd2);
    chk("t1_sub_carry", 32'(rsp_carry), 32'd1);
    req_valid = 4'b0100;
    set_req(2, 8, 2, addsub_pkg::MODE_SUB);
    step();
    chk("t2_sub_sum", 32'(rsp_sum), 32'd6);
    chk("t2_sub_carry", 32'(rsp_carry), 32'd1);
    chk("t2_sub_id", 32'(rsp_id), 32'd2);
    set_req(2, 2, 8, addsub_pkg::MODE_SUB);
    step();
    chk("t2_borrow_sum", 32'(rsp_sum), 32'hA);
    chk("t2_borrow_carry", 32'(rsp_carry), 32'd0);
    set_req(2, 15, 1, addsub_pkg::MODE_ADD);
    step();
    chk("t2_wrap_sum", 32'(rsp_sum), 32'd0);
    chk("t2_wrap_carry", 32'(rsp_carry), 32'd1);
`ifdef ADDSUB_OVF_EN
    set_req(2, 7, 1, addsub_pkg::MODE_ADD);
    step();
    chk("t6_ovf_add", 32'(rsp_ovf), 32'd1);
    set_req(2, 8, 1, addsub_pkg::MODE_SUB);
    step();
    chk("t6_ovf_sub", 32'(rsp_ovf), 32'd1);
    set_req(2, 3, 2, addsub_pkg::MODE_ADD);
    step();
    chk("t6_no_ovf", 32'(rsp_ovf), 32'd0);
`endif
    req_valid = 4'b1111;
    for (int k = 0; k < N; k++) set_req(k, $urandom_range(15), $urandom_range(15), 1'($urandom_range(1)));
    for (int c = 0; c < 8; c++) step();
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) step();
    chk("t4_held_ready", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    step();
    chk("t4_no_bubble", 32'(rsp_valid), 32'd1);
    req_valid = 4'b1010;
    rsp_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("t5_rst_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("t5_first_grant", 32'(req_ready), 32'b0010);
    step();
    chk("t5_first_id", 32'(rsp_id), 32'd1);
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(60) == 0);
      rsp_ready = ($urandom_range(3) != 0);
      req_valid = N'($urandom_range(15));
      for (int k = 0; k < N; k++) set_req(k, $urandom_range(15), $urandom_range(15), 1'($urandom_range(1)));
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
